// File: rtl/indication_serializer_pkg.sv
// Shared message geometry, field offsets and serializer state encoding.
package indication_serializer_pkg;

    localparam int unsigned MSG_W    = 96;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned TAG_LSB  = 64;
    localparam int unsigned METH_LSB = 32;
    localparam int unsigned V_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W0   = 2'd1,
        ST_W1   = 2'd2,
        ST_W2   = 2'd3
    } ser_state_t;

    // Extract one 32-bit word of a message starting at the given bit offset.
    function automatic logic [WORD_W-1:0] msg_field(input logic [MSG_W-1:0] msg,
                                                    input int unsigned    lsb);
        return msg[lsb +: WORD_W];
    endfunction

endpackage

// File: rtl/indication_serializer_if.sv
// Enqueue and beat handshake bundle between a producer/consumer and the serializer.
interface indication_serializer_if;
    import indication_serializer_pkg::*;

    logic                enq__ENA;
    logic [MSG_W-1:0]    enq_v;
    logic                enq__RDY;
    logic                beat__ENA;
    logic [WORD_W-1:0]   beat_data;
    logic                beat_last;
    logic                beat__RDY;

    modport master (
        output enq__ENA, enq_v, beat__RDY,
        input  enq__RDY, beat__ENA, beat_data, beat_last
    );

    modport slave (
        input  enq__ENA, enq_v, beat__RDY,
        output enq__RDY, beat__ENA, beat_data, beat_last
    );

endinterface

// File: rtl/indication_serializer_fifo.sv
// Message FIFO: DEPTH entries of 96 bits, registered pointers and occupancy.
module indication_fifo
    import indication_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [MSG_W-1:0]            i_data,
    output logic [MSG_W-1:0]            o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [MSG_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge CLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-two DEPTH.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/indication_serializer.sv
// Buffers 96-bit indication messages and emits each as three 32-bit beats.
module indication_serializer
    import indication_serializer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                      CLK,
    input  logic                      nRST,
    indication_serializer_if.slave    bus,
    output logic [15:0]               msg_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [15:0]       r_msg_count;

    logic [MSG_W-1:0]  w_head;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic              w_push;
    logic              w_xfer;
    logic              w_pop;
    logic              w_more;

    assign w_push = bus.enq__ENA && !w_full;
    assign w_xfer = (r_state != ST_IDLE) && bus.beat__RDY;
    assign w_pop  = w_xfer && (r_state == ST_W2);
    // After popping the head, another message remains if one was already queued
    // behind it or one is being accepted in the same cycle.
    assign w_more = (w_count > CNT_W'(1)) || w_push;

    indication_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.enq_v),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Next-state selection; IDLE looks at the incoming push so the first beat
    // appears the cycle right after the accepting edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_push || !w_empty) w_state_nxt = ST_W0;
            ST_W0:   if (w_xfer) w_state_nxt = ST_W1;
            ST_W1:   if (w_xfer) w_state_nxt = ST_W2;
            ST_W2:   if (w_xfer) w_state_nxt = w_more ? ST_W0 : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Completed-message counter, wraps at 16 bits.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_msg_count <= '0;
        end else if (w_pop) begin
            r_msg_count <= r_msg_count + 16'd1;
        end
    end

    // Beat word selection from the head message.
    always_comb begin
        bus.beat_data = '0;
        case (r_state)
            ST_W0:   bus.beat_data = msg_field(w_head, TAG_LSB);
            ST_W1:   bus.beat_data = msg_field(w_head, METH_LSB);
            ST_W2:   bus.beat_data = msg_field(w_head, V_LSB);
            default: bus.beat_data = '0;
        endcase
    end

    assign bus.enq__RDY  = !w_full;
    assign bus.beat__ENA = (r_state != ST_IDLE);
    assign bus.beat_last = (r_state == ST_W2);
    assign msg_count     = r_msg_count;

endmodule

// File: tb/tb_indication_serializer.sv
// Directed self-checking bench for indication_serializer (DEPTH = 2).
module tb_indication_serializer;

    logic        CLK;
    logic        nRST;
    logic [15:0] msg_count;
    int          n_cmp;
    int          n_fail;

    indication_serializer_if bus();

    indication_serializer #(
        .DEPTH (2)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus),
        .msg_count (msg_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check the current beat: valid, given word, given last flag.
    task automatic chk_beat(input string tag, input logic [31:0] data, input logic last);
        check({tag, ".ena"}, 32'(bus.beat__ENA), 32'd1);
        check({tag, ".data"}, bus.beat_data, data);
        check({tag, ".last"}, 32'(bus.beat_last), 32'(last));
    endtask

    task automatic chk_idle(input string tag, input logic [15:0] cnt);
        check({tag, ".ena"}, 32'(bus.beat__ENA), 32'd0);
        check({tag, ".data"}, bus.beat_data, 32'h0);
        check({tag, ".cnt"}, 32'(msg_count), 32'(cnt));
    endtask

    logic [95:0] mA, mB, mC, mD, mE, mF, mG, mH;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        mA = 96'h11111111_22222222_33333333;
        mB = 96'h44444444_55555555_66666666;
        mC = 96'h77777777_88888888_99999999;
        mD = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
        mE = 96'hE0E0E0E0_E1E1E1E1_E2E2E2E2;
        mF = 96'hF0F0F0F0_F1F1F1F1_F2F2F2F2;
        mG = 96'h00000009_00000007_CAFEF00D;
        mH = 96'h00000001_00000005_DEADBEEF;

        bus.enq__ENA  = 1'b0;
        bus.enq_v     = '0;
        bus.beat__RDY = 1'b1;
        nRST          = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst.ena", 32'(bus.beat__ENA), 32'd0);
        check("rst.last", 32'(bus.beat_last), 32'd0);
        check("rst.data", bus.beat_data, 32'h0);
        check("rst.rdy", 32'(bus.enq__RDY), 32'd1);
        check("rst.cnt", 32'(msg_count), 32'd0);
        nRST = 1'b1;
        tick();
        check("post_rst.ena", 32'(bus.beat__ENA), 32'd0);

        // Single message, first beat one cycle after enqueue
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mH;
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("single.w0", 32'h00000001, 1'b0);
        tick();
        chk_beat("single.w1", 32'h00000005, 1'b0);
        tick();
        chk_beat("single.w2", 32'hDEADBEEF, 1'b1);
        tick();
        chk_idle("single.done", 16'd1);

        // Backpressure for four cycles in W1
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mH;
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("bp.w0", 32'h00000001, 1'b0);
        tick();
        chk_beat("bp.w1", 32'h00000005, 1'b0);
        bus.beat__RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat("bp.hold", 32'h00000005, 1'b0);
        end
        bus.beat__RDY = 1'b1;
        tick();
        chk_beat("bp.w2", 32'hDEADBEEF, 1'b1);
        tick();
        chk_idle("bp.done", 16'd2);

        // Full: third enqueue while full is ignored
        bus.beat__RDY = 1'b0;
        bus.enq__ENA  = 1'b1;
        bus.enq_v     = mA;
        tick();
        check("full.rdy1", 32'(bus.enq__RDY), 32'd1);
        bus.enq_v = mB;
        tick();
        check("full.rdy2", 32'(bus.enq__RDY), 32'd0);
        bus.enq_v = mC;
        tick();
        bus.enq__ENA = 1'b0;
        check("full.rdy3", 32'(bus.enq__RDY), 32'd0);
        bus.beat__RDY = 1'b1;
        chk_beat("full.a0", mA[95:64], 1'b0);
        tick();
        chk_beat("full.a1", mA[63:32], 1'b0);
        tick();
        chk_beat("full.a2", mA[31:0], 1'b1);
        tick();
        chk_beat("full.b0", mB[95:64], 1'b0);
        tick();
        chk_beat("full.b1", mB[63:32], 1'b0);
        tick();
        chk_beat("full.b2", mB[31:0], 1'b1);
        tick();
        chk_idle("full.done", 16'd4);

        // Full FIFO with a pending enqueue across the W2 pop
        bus.beat__RDY = 1'b0;
        bus.enq__ENA  = 1'b1;
        bus.enq_v     = mA;
        tick();
        bus.enq_v = mB;
        tick();
        bus.enq_v     = mC;
        bus.beat__RDY = 1'b1;
        chk_beat("sim.a0", mA[95:64], 1'b0);
        check("sim.rdy_a0", 32'(bus.enq__RDY), 32'd0);
        tick();
        chk_beat("sim.a1", mA[63:32], 1'b0);
        tick();
        chk_beat("sim.a2", mA[31:0], 1'b1);
        check("sim.rdy_a2", 32'(bus.enq__RDY), 32'd0);
        tick();
        chk_beat("sim.b0", mB[95:64], 1'b0);
        check("sim.rdy_b0", 32'(bus.enq__RDY), 32'd1);
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("sim.b1", mB[63:32], 1'b0);
        check("sim.rdy_b1", 32'(bus.enq__RDY), 32'd0);
        tick();
        chk_beat("sim.b2", mB[31:0], 1'b1);
        tick();
        chk_beat("sim.c0", mC[95:64], 1'b0);
        tick();
        chk_beat("sim.c1", mC[63:32], 1'b0);
        tick();
        chk_beat("sim.c2", mC[31:0], 1'b1);
        // Accept and pop on the same edge with one message in the FIFO
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mD;
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("sim.d0", mD[95:64], 1'b0);
        check("sim.rdy_d0", 32'(bus.enq__RDY), 32'd1);
        tick();
        chk_beat("sim.d1", mD[63:32], 1'b0);
        tick();
        chk_beat("sim.d2", mD[31:0], 1'b1);
        tick();
        chk_idle("sim.done", 16'd8);

        // Reset during W1 with a second message queued
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mE;
        tick();
        bus.enq_v = mF;
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("rmid.e1", mE[63:32], 1'b0);
        nRST = 1'b0;
        tick();
        chk_idle("rmid.in", 16'd0);
        check("rmid.rdy", 32'(bus.enq__RDY), 32'd1);
        nRST = 1'b1;
        tick();
        check("rmid.rel_ena", 32'(bus.beat__ENA), 32'd0);
        check("rmid.rel_rdy", 32'(bus.enq__RDY), 32'd1);
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mG;
        tick();
        bus.enq__ENA = 1'b0;
        chk_beat("rmid.g0", mG[95:64], 1'b0);
        tick();
        chk_beat("rmid.g1", mG[63:32], 1'b0);
        tick();
        chk_beat("rmid.g2", mG[31:0], 1'b1);
        tick();
        chk_idle("rmid.done", 16'd1);

        // Counter wrap from 16'hFFFF
        force dut.r_msg_count = 16'hFFFF;
        #1;
        release dut.r_msg_count;
        check("wrap.pre", 32'(msg_count), 32'h0000FFFF);
        bus.enq__ENA = 1'b1;
        bus.enq_v    = mH;
        tick();
        bus.enq__ENA = 1'b0;
        tick();
        tick();
        chk_beat("wrap.w2", 32'hDEADBEEF, 1'b1);
        check("wrap.cnt_w2", 32'(msg_count), 32'h0000FFFF);
        tick();
        chk_idle("wrap.done", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
